// File: rtl/lsq_param_if.sv
// Memory-side bus of the load/store queue: one request channel, one response strobe.
//
// Handshake: a request transfers on a clock edge where mem_req_valid and
// mem_req_ready are both high. The master keeps mem_req_valid and every
// request field stable until that edge, except that a branch flush may
// withdraw a not-yet-accepted speculative request. mem_resp_valid is a
// one-cycle strobe with no back-pressure; it carries load data or a store ack.
interface lsq_param_if #(parameter int XLEN = 32);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_wr;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [1:0]      mem_req_size;
  logic            mem_req_signed;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata,
           mem_req_size, mem_req_signed,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata,
           mem_req_size, mem_req_signed,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/lsq_param.sv
// In-order load/store queue: circular buffer with CDB wakeup, commit gating
// for stores and IO loads, flush of speculative entries and one outstanding
// memory request at a time.
module lsq_param #(
  parameter int              DEPTH   = 16,
  parameter int              TAG_W   = 4,
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] IO_BASE = 32'h30000,
  localparam int             PTR_W   = $clog2(DEPTH),
  localparam int             CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_is_load,
  input  logic [1:0]       disp_size,
  input  logic             disp_signed,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             flush_in,
  lsq_param_if.master      mem,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_val,
  output logic [CNT_W-1:0] count,
  output logic [0:0]       state_dbg
);
  localparam logic [TAG_W-1:0] NONE  = '1;
  localparam logic [0:0]       IDLE  = 1'b0;
  localparam logic [0:0]       WAIT  = 1'b1;
  localparam int               SUM_W = CNT_W + 1;

  logic [DEPTH-1:0] e_valid, e_is_load, e_signed, e_committed;
  logic [TAG_W-1:0] e_tag [DEPTH];
  logic [TAG_W-1:0] e_qj  [DEPTH];
  logic [TAG_W-1:0] e_qk  [DEPTH];
  logic [1:0]       e_size[DEPTH];
  logic [XLEN-1:0]  e_imm [DEPTH];
  logic [XLEN-1:0]  e_vj  [DEPTH];
  logic [XLEN-1:0]  e_vk  [DEPTH];

  logic [PTR_W-1:0] front, rear, front_n, rear_flush;
  logic [CNT_W-1:0] ncommit, ncommit_n;
  logic [SUM_W-1:0] rear_sum;
  logic [0:0]       state;
  logic             discard;

  logic [DEPTH-1:0] commit_hit;
  logic [XLEN-1:0]  head_addr;
  logic             head_elig, head_comm, commit_inc;
  logic             flush_eff, disp_fire, req_fire, resp_fire, kill_head, pop;
  logic [TAG_W-1:0] disp_qk_eff;
  logic             j_wake, k_wake;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign state_dbg  = state;
  assign flush_eff  = flush_in & rdy_in;
  // Flush wins over dispatch; a full queue refuses even if a pop happens now.
  assign disp_fire  = rdy_in & disp_valid & disp_ready & ~flush_in;

  assign head_addr = e_imm[front] + e_vj[front];
  assign head_elig = e_valid[front] & (e_qj[front] == NONE) & (e_qk[front] == NONE) &
                     (e_committed[front] | (e_is_load[front] & (head_addr < IO_BASE)));

  assign mem.mem_req_valid  = (state == IDLE) & head_elig;
  assign mem.mem_req_wr     = ~e_is_load[front];
  assign mem.mem_req_addr   = head_addr;
  assign mem.mem_req_wdata  = e_vk[front];
  assign mem.mem_req_size   = e_size[front];
  assign mem.mem_req_signed = e_signed[front];

  assign req_fire  = rdy_in & mem.mem_req_valid & mem.mem_req_ready;
  assign resp_fire = rdy_in & (state == WAIT) & mem.mem_resp_valid;
  // The in-flight head is abandoned when a flush hits it while uncommitted;
  // its response will be swallowed by the discard flag.
  assign kill_head = flush_eff & ~e_committed[front] &
                     (((state == WAIT) & ~discard) | req_fire);
  assign pop       = resp_fire & ~discard & ~kill_head;
  assign head_comm = e_committed[front] | commit_hit[front];
  assign commit_inc = |commit_hit;

  assign disp_qk_eff = disp_is_load ? NONE : disp_qk;
  assign j_wake = cdb_valid & (disp_qj != NONE) & (disp_qj == cdb_tag);
  assign k_wake = cdb_valid & (disp_qk_eff != NONE) & (disp_qk_eff == cdb_tag);

  // Commit match per entry; a flush in the same cycle suppresses it.
  always_comb begin
    commit_hit = '0;
    for (int i = 0; i < DEPTH; i++)
      commit_hit[i] = rdy_in & commit_valid & ~flush_in & e_valid[i] &
                      ~e_committed[i] & (e_tag[i] == commit_tag);
  end

  // Next front, committed count and post-flush rear (front + ncommit mod DEPTH).
  always_comb begin
    front_n = front;
    if (pop || kill_head) front_n = ptr_inc(front);
    ncommit_n = ncommit + CNT_W'(commit_inc) - CNT_W'(pop & head_comm);
    rear_sum  = SUM_W'(front_n) + SUM_W'(ncommit_n);
    if (rear_sum >= SUM_W'(DEPTH)) rear_sum = rear_sum - SUM_W'(DEPTH);
    rear_flush = PTR_W'(rear_sum);
  end

  // Entry control bits: allocate, commit, pop and flush invalidation.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      e_valid     <= '0;
      e_committed <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_hit[i]) e_committed[i] <= 1'b1;
        if (flush_eff && e_valid[i] && !e_committed[i]) e_valid[i] <= 1'b0;
      end
      if (pop) e_valid[front] <= 1'b0;
      if (disp_fire) begin
        e_valid[rear]     <= 1'b1;
        e_committed[rear] <= 1'b0;
      end
    end
  end

  // Entry payload: CDB wakeup of waiting operands and dispatch writes.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && e_valid[i] && e_qj[i] != NONE && e_qj[i] == cdb_tag) begin
          e_vj[i] <= cdb_val;
          e_qj[i] <= NONE;
        end
        if (cdb_valid && e_valid[i] && e_qk[i] != NONE && e_qk[i] == cdb_tag) begin
          e_vk[i] <= cdb_val;
          e_qk[i] <= NONE;
        end
      end
      if (disp_fire) begin
        e_tag[rear]     <= disp_tag;
        e_is_load[rear] <= disp_is_load;
        e_size[rear]    <= disp_size;
        e_signed[rear]  <= disp_signed;
        e_imm[rear]     <= disp_imm;
        e_vj[rear]      <= j_wake ? cdb_val : disp_vj;
        e_qj[rear]      <= j_wake ? NONE : disp_qj;
        e_vk[rear]      <= k_wake ? cdb_val : disp_vk;
        e_qk[rear]      <= k_wake ? NONE : disp_qk_eff;
      end
    end
  end

  // Pointers, occupancy, issue FSM and the registered load-result port.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      front     <= '0;
      rear      <= '0;
      count     <= '0;
      ncommit   <= '0;
      state     <= IDLE;
      discard   <= 1'b0;
      out_valid <= 1'b0;
      out_tag   <= NONE;
      out_val   <= '0;
    end else if (rdy_in) begin
      front   <= front_n;
      ncommit <= ncommit_n;
      if (flush_eff) begin
        rear  <= rear_flush;
        count <= ncommit_n;
      end else begin
        if (disp_fire) rear <= ptr_inc(rear);
        count <= count + CNT_W'(disp_fire) - CNT_W'(pop);
      end
      if (state == IDLE) begin
        if (req_fire) begin
          state   <= WAIT;
          discard <= kill_head;
        end
      end else begin
        if (resp_fire) begin
          state   <= IDLE;
          discard <= 1'b0;
        end else if (kill_head) begin
          discard <= 1'b1;
        end
      end
      out_valid <= pop & e_is_load[front];
      if (pop && e_is_load[front]) begin
        out_tag <= e_tag[front];
        out_val <= mem.mem_resp_rdata;
      end
    end
  end
endmodule

// File: tb/tb_lsq_param.sv
// Bench for lsq_param: table of loads plus hand-written multi-cycle sequences.
module tb_lsq_param;
  localparam int         DEPTH = 16;
  localparam int         TAG_W = 4;
  localparam int         XLEN  = 32;
  localparam logic [3:0] NONE  = 4'hF;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        disp_valid, disp_ready, disp_is_load, disp_signed;
  logic [1:0]  disp_size;
  logic [3:0]  disp_tag, disp_qj, disp_qk;
  logic [31:0] disp_imm, disp_vj, disp_vk;
  logic        cdb_valid, commit_valid, flush_in;
  logic [3:0]  cdb_tag, commit_tag;
  logic [31:0] cdb_val;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_val;
  logic [4:0]  count;
  logic [0:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];

  lsq_param_if #(.XLEN(XLEN)) mem();

  lsq_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .IO_BASE(32'h30000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_load(disp_is_load),
    .disp_size(disp_size), .disp_signed(disp_signed), .disp_tag(disp_tag),
    .disp_imm(disp_imm), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .flush_in(flush_in),
    .mem(mem), .out_valid(out_valid), .out_tag(out_tag), .out_val(out_val),
    .count(count), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk_in = ~clk_in;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every out_valid cycle must match the oldest expected result.
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got tag %0d val %h, required no output", out_tag, out_val);
      end else begin
        check("out_result", {28'h0, out_tag, out_val}, {28'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic dispatch(input logic ld, input logic [1:0] sz, input logic sg,
                          input logic [3:0] tag, input logic [31:0] imm, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk);
    disp_is_load = ld; disp_size = sz; disp_signed = sg; disp_tag = tag;
    disp_imm = imm; disp_vj = vj; disp_vk = vk; disp_qj = qj; disp_qk = qk;
    disp_valid = 1'b1;
    @(posedge clk_in); #1;
    disp_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] tag);
    commit_valid = 1'b1; commit_tag = tag;
    @(posedge clk_in); #1;
    commit_valid = 1'b0;
  endtask

  task automatic wait_req(input string name, output bit ok);
    int n = 0;
    @(negedge clk_in);
    while (mem.mem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    ok = (mem.mem_req_valid === 1'b1);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no request in 20 cycles, required mem_req_valid=1", name);
    end
  endtask

  // Accept one request, check its fields, answer after one idle cycle.
  task automatic serve(input string name, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic [1:0] sz, input logic sg,
                       input logic [31:0] rdata, input logic [3:0] tag);
    bit ok;
    wait_req(name, ok);
    if (!ok) return;
    check({name, "_addr"}, 64'(mem.mem_req_addr), 64'(addr));
    check({name, "_wr"}, 64'(mem.mem_req_wr), 64'(wr));
    check({name, "_size"}, 64'(mem.mem_req_size), 64'(sz));
    if (wr) check({name, "_wdata"}, 64'(mem.mem_req_wdata), 64'(wdata));
    else    check({name, "_signed"}, 64'(mem.mem_req_signed), 64'(sg));
    mem.mem_req_ready = 1'b1;
    @(posedge clk_in); #1;
    mem.mem_req_ready = 1'b0;
    @(negedge clk_in);
    check({name, "_wait_state"}, 64'(state_dbg), 64'd1);
    check({name, "_req_dropped"}, 64'(mem.mem_req_valid), 64'd0);
    @(posedge clk_in); #1;
    mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = rdata;
    if (!wr) exp_q.push_back({tag, rdata});
    @(posedge clk_in); #1;
    mem.mem_resp_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  size;
    logic        sg;
    logic [3:0]  tag;
    logic [31:0] imm;
    logic [31:0] vj;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
  } ld_vec_t;

  ld_vec_t vecs[5];
  bit ok;

  initial begin
    vecs[0] = '{2'b00, 1'b0, 4'd3,  32'h0000_0004, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0104};
    vecs[1] = '{2'b01, 1'b1, 4'd1,  32'hFFFF_FFF0, 32'h0000_0020, 32'hFFFF_8001, 32'h0000_0010};
    vecs[2] = '{2'b10, 1'b0, 4'd2,  32'h0000_FFFF, 32'h0002_0000, 32'h0000_007F, 32'h0002_FFFF};
    vecs[3] = '{2'b10, 1'b1, 4'd14, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FF80, 32'h0000_0000};
    vecs[4] = '{2'b00, 1'b0, 4'd0,  32'h0000_0010, 32'h0000_1000, 32'h1234_5678, 32'h0000_1010};

    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    disp_valid = 1'b0; disp_is_load = 1'b0; disp_size = 2'b00; disp_signed = 1'b0;
    disp_tag = 4'd0; disp_imm = '0; disp_vj = '0; disp_vk = '0; disp_qj = NONE; disp_qk = NONE;
    cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_val = '0; commit_valid = 1'b0; commit_tag = 4'd0;
    mem.mem_req_ready = 1'b0; mem.mem_resp_valid = 1'b0; mem.mem_resp_rdata = '0;

    // Reset
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    check("reset_count", 64'(count), 64'd0);
    check("reset_req_valid", 64'(mem.mem_req_valid), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'(NONE));
    check("reset_out_val", 64'(out_val), 64'd0);
    check("reset_disp_ready", 64'(disp_ready), 64'd1);
    @(posedge clk_in); #1;

    // Speculative non-IO loads from the table
    for (int i = 0; i < 5; i++) begin
      dispatch(1'b1, vecs[i].size, vecs[i].sg, vecs[i].tag, vecs[i].imm, vecs[i].vj, 32'h0, NONE, 4'd7);
      serve($sformatf("load%0d", i), vecs[i].exp_addr, 1'b0, 32'h0, vecs[i].size, vecs[i].sg,
            vecs[i].rdata, vecs[i].tag);
      @(negedge clk_in);
      check($sformatf("load%0d_count", i), 64'(count), 64'd0);
      @(posedge clk_in); #1;
    end

    // Store waits for data via CDB and then for commit
    dispatch(1'b0, 2'b00, 1'b0, 4'd5, 32'h0, 32'h200, 32'h0, NONE, 4'd7);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("sw_wait_data", 64'(mem.mem_req_valid), 64'd0);
    @(posedge clk_in); #1;
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_val = 32'h55;
    @(posedge clk_in); #1;
    cdb_valid = 1'b0;
    @(negedge clk_in);
    check("sw_wait_commit", 64'(mem.mem_req_valid), 64'd0);
    @(posedge clk_in); #1;
    commit(4'd5);
    serve("sw", 32'h200, 1'b1, 32'h55, 2'b00, 1'b0, 32'h0, 4'd5);
    @(negedge clk_in);
    check("sw_count", 64'(count), 64'd0);
    @(posedge clk_in); #1;

    // Same-cycle CDB bypass at dispatch
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_val = 32'h300;
    dispatch(1'b0, 2'b01, 1'b0, 4'd4, 32'h8, 32'h0, 32'h77, 4'd6, NONE);
    cdb_valid = 1'b0;
    commit(4'd4);
    serve("sw_bypass", 32'h308, 1'b1, 32'h77, 2'b01, 1'b0, 32'h0, 4'd4);

    // IO load is held until commit
    dispatch(1'b1, 2'b00, 1'b0, 4'd8, 32'h0, 32'h30000, 32'h0, NONE, NONE);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("io_hold", 64'(mem.mem_req_valid), 64'd0);
    @(posedge clk_in); #1;
    commit(4'd8);
    serve("io_ld", 32'h30000, 1'b0, 32'h0, 2'b00, 1'b0, 32'hCAFE_0001, 4'd8);

    // Fill to DEPTH with IO loads (rear wraps), reject when full
    for (int i = 0; i < DEPTH; i++)
      dispatch(1'b1, 2'b00, 1'b0, (i < 15) ? 4'(i) : 4'd14, 32'(i * 4), 32'h30000, 32'h0, NONE, NONE);
    @(negedge clk_in);
    check("full_count", 64'(count), 64'd16);
    check("full_disp_ready", 64'(disp_ready), 64'd0);
    @(posedge clk_in); #1;
    dispatch(1'b1, 2'b00, 1'b0, 4'd9, 32'h0, 32'h30000, 32'h0, NONE, NONE);
    @(negedge clk_in);
    check("full_reject", 64'(count), 64'd16);
    @(posedge clk_in); #1;

    // Pop and dispatch in the same cycle while full: dispatch is refused
    commit(4'd0);
    wait_req("full_pop", ok);
    if (ok) begin
      check("full_pop_addr", 64'(mem.mem_req_addr), 64'h30000);
      mem.mem_req_ready = 1'b1;
      @(posedge clk_in); #1;
      mem.mem_req_ready = 1'b0;
      @(posedge clk_in); #1;
      mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = 32'hA000_0000;
      exp_q.push_back({4'd0, 32'hA000_0000});
      disp_is_load = 1'b1; disp_tag = 4'd12; disp_imm = 32'h100; disp_vj = 32'h30000;
      disp_qj = NONE; disp_qk = NONE; disp_valid = 1'b1;
      @(posedge clk_in); #1;
      mem.mem_resp_valid = 1'b0;
      @(negedge clk_in);
      check("pop_full_no_disp", 64'(count), 64'd15);
      check("pop_ready_again", 64'(disp_ready), 64'd1);
      @(posedge clk_in); #1;
      disp_valid = 1'b0;
      @(negedge clk_in);
      check("refill_count", 64'(count), 64'd16);
      @(posedge clk_in); #1;
    end

    // Drain across the wrap in program order
    for (int i = 1; i < 8; i++) begin
      commit(4'(i));
      serve($sformatf("wrap%0d", i), 32'h30000 + 32'(i * 4), 1'b0, 32'h0, 2'b00, 1'b0,
            32'hA000_0000 + 32'(i), 4'(i));
    end
    @(negedge clk_in);
    check("drain_count", 64'(count), 64'd9);
    @(posedge clk_in); #1;

    // Flush with a same-cycle dispatch: flush wins, nothing committed remains
    flush_in = 1'b1;
    disp_is_load = 1'b1; disp_tag = 4'd3; disp_imm = 32'h0; disp_vj = 32'h100; disp_valid = 1'b1;
    @(posedge clk_in); #1;
    flush_in = 1'b0; disp_valid = 1'b0;
    @(negedge clk_in);
    check("flush_all_count", 64'(count), 64'd0);
    check("flush_all_req", 64'(mem.mem_req_valid), 64'd0);
    @(posedge clk_in); #1;

    // Uncommitted load in flight, committed store behind it, then flush
    dispatch(1'b1, 2'b00, 1'b0, 4'd10, 32'h0, 32'h500, 32'h0, NONE, NONE);
    wait_req("spec_ld", ok);
    if (ok) begin
      check("spec_ld_addr", 64'(mem.mem_req_addr), 64'h500);
      mem.mem_req_ready = 1'b1;
      @(posedge clk_in); #1;
      mem.mem_req_ready = 1'b0;
      dispatch(1'b0, 2'b00, 1'b0, 4'd11, 32'h0, 32'h600, 32'hABCD, NONE, NONE);
      commit(4'd11);
      @(negedge clk_in);
      check("pre_flush_count", 64'(count), 64'd2);
      @(posedge clk_in); #1;
      flush_in = 1'b1;
      @(posedge clk_in); #1;
      flush_in = 1'b0;
      @(negedge clk_in);
      check("flush_keep_count", 64'(count), 64'd1);
      check("flush_still_wait", 64'(state_dbg), 64'd1);
      @(posedge clk_in); #1;
      mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = 32'h1111;
      @(posedge clk_in); #1;
      mem.mem_resp_valid = 1'b0;
      @(negedge clk_in);
      check("discard_count", 64'(count), 64'd1);
      check("discard_idle", 64'(state_dbg), 64'd0);
      serve("sw_after_flush", 32'h600, 1'b1, 32'hABCD, 2'b00, 1'b0, 32'h0, 4'd11);
      @(negedge clk_in);
      check("sw_after_flush_count", 64'(count), 64'd0);
      @(posedge clk_in); #1;
    end

    // rdy_in low freezes a pending request even with ready asserted
    dispatch(1'b1, 2'b00, 1'b0, 4'd13, 32'h4, 32'h700, 32'h0, NONE, NONE);
    wait_req("freeze", ok);
    rdy_in = 1'b0; mem.mem_req_ready = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("freeze_req_valid", 64'(mem.mem_req_valid), 64'd1);
    check("freeze_req_addr", 64'(mem.mem_req_addr), 64'h704);
    check("freeze_state", 64'(state_dbg), 64'd0);
    @(posedge clk_in); #1;
    rdy_in = 1'b1; mem.mem_req_ready = 1'b0;
    serve("after_freeze", 32'h704, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0BAD_F00D, 4'd13);

    // Reset mid-transaction: the late response is ignored
    dispatch(1'b1, 2'b00, 1'b0, 4'd9, 32'h0, 32'h800, 32'h0, NONE, NONE);
    wait_req("rst_mid", ok);
    mem.mem_req_ready = 1'b1;
    @(posedge clk_in); #1;
    mem.mem_req_ready = 1'b0;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = 32'h2222;
    @(posedge clk_in); #1;
    mem.mem_resp_valid = 1'b0;
    @(negedge clk_in);
    check("rst_mid_count", 64'(count), 64'd0);
    check("rst_mid_state", 64'(state_dbg), 64'd0);
    check("rst_mid_out_tag", 64'(out_tag), 64'(NONE));

    repeat (3) @(posedge clk_in);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsq_param.md
Name: lsq_param

Overview:
- Parametrised successor of the in-order load/store buffer in the Tomasulo core. Sits between dispatch, the CDB, the ROB commit port and the memory controller.
- Holds DEPTH entries in a circular queue with an occupancy counter, so every slot is usable. Wakes up operands from the CDB and issues memory operations strictly in program order over a valid/ready handshake.
- New behaviour:
  - stores and IO-region loads are gated on ROB commit;
  - speculative entries are flushed while committed stores are preserved;
  - a late load response is discarded after a flush.

Parameters:
- DEPTH, 16, queue entries (≥2, any value, not just a power of two).
- TAG_W, 4, ROB tag width; the all-ones tag means None.
- XLEN, 32, data and address width.
- IO_BASE, 32'h30000, addresses ≥ IO_BASE are IO and are non-speculative.

Ports:
- clk_in in 1: clock, single domain.
- rst_in in 1: synchronous, active-low reset.
- rdy_in in 1: 0 freezes all state; outputs hold.
- disp_valid in 1: dispatch strobe.
- disp_ready out 1: equals count < DEPTH.
- disp_is_load in 1: 1 = load, 0 = store.
- disp_size in 2: 00 word, 01 half, 10 byte.
- disp_signed in 1: sign-extend load data.
- disp_tag in TAG_W: ROB tag of the instruction.
- disp_imm in XLEN: address offset.
- disp_vj, disp_vk in XLEN: base and store-data values.
- disp_qj, disp_qk in TAG_W: producer tags; None means the value is ready.
- cdb_valid in 1, cdb_tag in TAG_W, cdb_val in XLEN: result broadcast.
- commit_valid in 1, commit_tag in TAG_W: ROB head retiring.
- flush_in in 1: branch mispredict.
- mem_req_valid out 1; mem_req_ready in 1: request handshake.
- mem_req_wr out 1; mem_req_addr out XLEN; mem_req_wdata out XLEN; mem_req_size out 2; mem_req_signed out 1.
- mem_resp_valid in 1, mem_resp_rdata in XLEN: response or write ack.
- out_valid out 1, out_tag out TAG_W, out_val out XLEN: load result to the ROB and CDB.
- count out $clog2(DEPTH+1): current occupancy.

Behaviour:
- Reset (rst_in == 0 at a clock edge):
  - front, rear, count, ncommit and all entry valid bits go to 0; state goes to IDLE.
  - mem_req_valid = 0, out_valid = 0, out_tag = None, out_val = 0.
  - Reset mid-transaction drops the outstanding request; a later mem_resp_valid while IDLE is ignored.
- Entry fields: tag, is_load, size, signed, imm, vj, vk, qj, qk, committed.
  - For loads, qk is forced to None at dispatch.
- Dispatch fires on disp_valid & disp_ready & rdy_in.
  - Writes the entry at rear. rear wraps DEPTH-1 → 0.
  - If cdb_valid and the CDB tag matches disp_qj or disp_qk in the same cycle, the entry captures cdb_val and sets that q to None.
- CDB wakeup: every valid entry with q == cdb_tag (q ≠ None) takes cdb_val and sets q to None.
- Commit: a valid entry whose tag == commit_tag sets committed = 1, and ncommit increments.
- Address: addr = imm + vj, mod 2^XLEN.
- Head eligibility: valid & qj == None & qk == None, and either committed or (is_load & addr < IO_BASE).
- FSM state IDLE:
  - mem_req_valid = eligible head. Request fields come from the head entry; wdata = vk.
  - The request stays stable until mem_req_ready is seen.
  - On valid & ready, go to WAIT.
- FSM state WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid, pop the head: front advances, count decrements, and ncommit decrements if the entry was committed. Return to IDLE.
  - For a load, out_valid = 1 on the next cycle for exactly one cycle, with out_tag = entry tag and out_val = mem_resp_rdata (already extended by memory).
  - Stores produce no out_valid.
- One outstanding request at a time; issue to memory is strictly in order.
- Same-cycle dispatch and pop: both take effect. disp_ready does not anticipate the pop, so dispatch into a full queue fails even when a pop happens that cycle.
- Flush (takes priority over dispatch in the same cycle):
  - Invalidate all uncommitted entries; committed entries always form a prefix from front.
  - rear = front + ncommit (mod DEPTH); count = ncommit.
  - If in WAIT on an uncommitted load, set the discard flag. The later response is consumed with no out_valid and no pop, then the FSM returns to IDLE.
  - A same-cycle CDB or commit for a flushed entry has no effect.
- rdy_in == 0: no state changes. Any mem_req_valid already asserted stays asserted with unchanged fields.

Test Plan:
- Reset low 2 cycles, then high → count = 0, mem_req_valid = 0, out_tag = None.
- Dispatch LW tag 3, vj = 0x100, imm = 4, qj = None; mem ready next cycle; resp 0xDEADBEEF two cycles later → request addr 0x104, wr = 0, then out_valid for one cycle with tag 3 and 0xDEADBEEF.
- Dispatch SW tag 5 with qk = 7; CDB tag 7 with 0x55 → no request. Commit tag 5 → request wr = 1, wdata 0x55; ack pops it, no out_valid.
- LW with addr 0x30000 (IO) → held until commit_tag matches, then issued.
- Fill DEPTH = 16 → disp_ready = 0. Pop one → disp_ready = 1. Dispatch across the wrap → rear goes 15 → 0.
- Committed SW, then uncommitted LW in WAIT; flush → count = 1; the LW response is discarded (no out_valid); the SW issues next.
